// File: rtl/display_timing_ctrl.sv
// Video timing sequencer for the DVI path: counts pixel coordinates and decodes
// registered, coordinate-aligned sync/de/strobe outputs plus start-up blanking.
module display_timing_ctrl #(
  parameter int H_RES          = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_RES          = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit H_POL          = 1'b0,
  parameter bit V_POL          = 1'b0,
  parameter int STARTUP_FRAMES = 2,
  parameter int CORDW          = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             ready
);

  localparam int H_TOT_I = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT_I = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] H_SS_C   = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] H_SE_C   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] H_MAX_C  = CORDW'(H_TOT_I - 1);
  localparam logic [CORDW-1:0] V_RES_C  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] V_SS_C   = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] V_SE_C   = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] V_MAX_C  = CORDW'(V_TOT_I - 1);

  // Counter only has to reach STARTUP_FRAMES; it stops once ready is set.
  localparam int SW = $clog2(STARTUP_FRAMES + 2);
  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_FRAMES);

  if (longint'(H_TOT_I) >= (longint'(1) << CORDW) ||
      longint'(V_TOT_I) >= (longint'(1) << CORDW)) begin : g_bad_total
    $error("display_timing_ctrl: H_TOT/V_TOT do not fit in CORDW bits");
  end
  if (H_RES == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_RES == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("display_timing_ctrl: resolution, porch and sync widths must be non-zero");
  end
  if (STARTUP_FRAMES < 0) begin : g_bad_startup
    $error("display_timing_ctrl: STARTUP_FRAMES must be non-negative");
  end

  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             de_q, de_d, frame_q, frame_d, line_q, line_d;
  logic             ready_q, ready_d;
  logic [SW-1:0]    su_cnt_q, su_cnt_d;

  // Outputs are decoded from the next coordinates so they register alongside them.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    sx_d     = sx_q + CORDW'(1);
    sy_d     = sy_q;
    su_cnt_d = su_cnt_q;
    ready_d  = ready_q;

    if (sx_q == H_MAX_C) begin
      sx_d = '0;
      sy_d = (sy_q == V_MAX_C) ? '0 : sy_q + CORDW'(1);
    end

    line_d  = (sx_d == '0);
    frame_d = line_d && (sy_d == '0);

    // Frame strobe number STARTUP_FRAMES+1 is the first live frame.
    if (frame_d && !ready_q) begin
      if (su_cnt_q == SU_LAST) ready_d = 1'b1;
      else                     su_cnt_d = su_cnt_q + SW'(1);
    end

    hsync_d = (sx_d >= H_SS_C && sx_d < H_SE_C) ? H_POL : ~H_POL;
    vsync_d = (sy_d >= V_SS_C && sy_d < V_SE_C) ? V_POL : ~V_POL;
    de_d    = (sx_d < H_RES_C) && (sy_d < V_RES_C) && ready_d;
  end

  // Reset parks the counters at their maxima so the first live cycle is (0,0).
  always_ff @(posedge clk_pix) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      sx_q     <= H_MAX_C;
      sy_q     <= V_MAX_C;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      de_q     <= 1'b0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
      ready_q  <= 1'b0;
      su_cnt_q <= '0;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      frame_q  <= frame_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      su_cnt_q <= su_cnt_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign frame = frame_q;
  assign line  = line_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Bench for display_timing_ctrl: two small-geometry instances checked every cycle
// against an arithmetic model derived from the cycle count since reset release.
module tb_display_timing_ctrl;

  localparam int CW = 16;
  // Instance A: tiny geometry, active-low syncs, two blanked start-up frames.
  localparam int AHR = 4, AHF = 1, AHS = 1, AHB = 1;
  localparam int AVR = 3, AVF = 1, AVS = 1, AVB = 1, AST = 2;
  localparam int AHT = AHR + AHF + AHS + AHB, AVT = AVR + AVF + AVS + AVB;
  localparam int A_FT = AHT * AVT;
  // Instance B: active-high syncs, no start-up blanking.
  localparam int BHR = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVR = 5, BVF = 1, BVS = 2, BVB = 2, BST = 0;
  localparam int BHT = BHR + BHF + BHS + BHB, BVT = BVR + BVF + BVS + BVB;
  localparam int B_FT = BHT * BVT;

  typedef struct packed {
    logic          hsync, vsync, de, frame, line, ready;
    logic [CW-1:0] sx, sy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_hsync, a_vsync, a_de, a_frame, a_line, a_ready;
  logic [CW-1:0] a_sx, a_sy;
  logic          b_hsync, b_vsync, b_de, b_frame, b_line, b_ready;
  logic [CW-1:0] b_sx, b_sy;

  display_timing_ctrl #(
    .H_RES(AHR), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_RES(AVR), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .H_POL(1'b0), .V_POL(1'b0), .STARTUP_FRAMES(AST), .CORDW(CW)
  ) u_a (
    .clk_pix(clk), .rst(rst), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .frame(a_frame), .line(a_line), .sx(a_sx), .sy(a_sy), .ready(a_ready)
  );

  display_timing_ctrl #(
    .H_RES(BHR), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_RES(BVR), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .H_POL(1'b1), .V_POL(1'b1), .STARTUP_FRAMES(BST), .CORDW(CW)
  ) u_b (
    .clk_pix(clk), .rst(rst), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .frame(b_frame), .line(b_line), .sx(b_sx), .sy(b_sy), .ready(b_ready)
  );

  // Reference: outputs follow directly from t = cycles since reset released.
  function automatic obs_t model(int t, bit in_rst, int hr, int hf, int hs, int hb,
                                 int vr, int vf, int vs, int vb, int st, bit hp, bit vp);
    obs_t o;
    int htot, vtot, x, y, f;
    htot = hr + hf + hs + hb;
    vtot = vr + vf + vs + vb;
    if (in_rst) begin
      o.sx = CW'(htot - 1); o.sy = CW'(vtot - 1);
      o.hsync = ~hp; o.vsync = ~vp;
      o.de = 1'b0; o.frame = 1'b0; o.line = 1'b0; o.ready = 1'b0;
      return o;
    end
    x = t % htot;
    y = (t / htot) % vtot;
    f = t / (htot * vtot);
    o.sx    = CW'(x);
    o.sy    = CW'(y);
    o.hsync = (x >= hr + hf && x < hr + hf + hs) ? hp : ~hp;
    o.vsync = (y >= vr + vf && y < vr + vf + vs) ? vp : ~vp;
    o.ready = (f >= st);
    o.de    = (x < hr) && (y < vr) && o.ready;
    o.frame = (x == 0) && (y == 0);
    o.line  = (x == 0);
    return o;
  endfunction

  int t_m = 0;
  bit m_rst = 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      m_rst <= 1'b1;
      t_m   <= 0;
    end else begin
      t_m   <= m_rst ? 0 : t_m + 1;
      m_rst <= 1'b0;
    end
  end

  obs_t obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_hsync, a_vsync, a_de, a_frame, a_line, a_ready, a_sx, a_sy};
  assign obs_b = {b_hsync, b_vsync, b_de, b_frame, b_line, b_ready, b_sx, b_sy};
  assign exp_a = model(t_m, m_rst, AHR, AHF, AHS, AHB, AVR, AVF, AVS, AVB, AST, 1'b0, 1'b0);
  assign exp_b = model(t_m, m_rst, BHR, BHF, BHS, BHB, BVR, BVF, BVS, BVB, BST, 1'b1, 1'b1);

  int checks = 0;
  int passes = 0;

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) $display("FAIL reset_a cyc=%0d got=%h exp=%h", i, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL reset_b cyc=%0d got=%h exp=%h", i, obs_b, exp_b);
      else passes++;
    end
    checks++;
    if ({a_sx, a_sy, a_hsync, b_sx, b_sy, b_hsync, b_vsync} !==
        {CW'(AHT - 1), CW'(AVT - 1), 1'b1, CW'(BHT - 1), CW'(BVT - 1), 1'b0, 1'b0})
      $display("FAIL reset_values a=(%0d,%0d,%b) b=(%0d,%0d,%b%b)",
               a_sx, a_sy, a_hsync, b_sx, b_sy, b_hsync, b_vsync);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_sx, a_sy, a_frame, a_line, a_de, a_ready} !== {CW'(0), CW'(0), 4'b1100})
      $display("FAIL reset_release got sx=%0d sy=%0d fr=%b ln=%b de=%b rdy=%b exp 0,0,1,1,0,0",
               a_sx, a_sy, a_frame, a_line, a_de, a_ready);
    else passes++;
  endtask

  task automatic test_startup();
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 10 * A_FT) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs_a !== exp_a) $display("FAIL startup_a t=%0d got=%h exp=%h", t_m, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL startup_b t=%0d got=%h exp=%h", t_m, obs_b, exp_b);
      else passes++;
      if (a_ready) begin
        seen = 1'b1;
        checks++;
        if (t_m != 2 * A_FT || a_sx !== '0 || a_sy !== '0 || a_de !== 1'b1)
          $display("FAIL ready_rise t=%0d (%0d,%0d) de=%b exp t=%0d (0,0) de=1",
                   t_m, a_sx, a_sy, a_de, 2 * A_FT);
        else passes++;
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL startup_timeout ready=%b exp 1 within %0d cycles", a_ready, 10 * A_FT);
    end
  endtask

  task automatic test_polarity_frame();
    int n = 0;
    int hs = 0, vs = 0, de_n = 0, ln = 0, fr = 0;
    while (!b_frame && n < 2 * B_FT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!b_frame) begin
      $display("FAIL frame_wait frame=%b exp 1 within %0d cycles", b_frame, 2 * B_FT);
      return;
    end
    passes++;
    for (int i = 0; i < B_FT; i++) begin
      hs += int'(b_hsync); vs += int'(b_vsync); de_n += int'(b_de);
      ln += int'(b_line);  fr += int'(b_frame);
      checks++;
      if (obs_b !== exp_b) $display("FAIL frame_b t=%0d got=%h exp=%h", t_m, obs_b, exp_b);
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (hs != BHS * BVT) $display("FAIL hsync_high_count got=%0d exp=%0d", hs, BHS * BVT);
    else passes++;
    checks++;
    if (vs != BVS * BHT) $display("FAIL vsync_high_count got=%0d exp=%0d", vs, BVS * BHT);
    else passes++;
    checks++;
    if (de_n != BHR * BVR) $display("FAIL de_count got=%0d exp=%0d", de_n, BHR * BVR);
    else passes++;
    checks++;
    if (ln != BVT || fr != 1) $display("FAIL strobe_count lines=%0d frames=%0d exp %0d,1", ln, fr, BVT);
    else passes++;
  endtask

  task automatic test_mid_frame_reset();
    int n = 0;
    while (!(a_ready && a_sx == CW'(3) && a_sy == CW'(2)) && n < 4 * A_FT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(a_ready && a_sx == CW'(3) && a_sy == CW'(2))) begin
      $display("FAIL midreset_wait got (%0d,%0d) rdy=%b exp (3,2) rdy=1", a_sx, a_sy, a_ready);
      return;
    end
    passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || a_de !== 1'b0 || a_sx !== CW'(AHT - 1))
      $display("FAIL midreset_abort rdy=%b de=%b sx=%0d exp 0,0,%0d", a_ready, a_de, a_sx, AHT - 1);
    else passes++;
    for (int i = 0; i < 4 * A_FT; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) $display("FAIL midreset_a t=%0d got=%h exp=%h", t_m, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL midreset_b t=%0d got=%h exp=%h", t_m, obs_b, exp_b);
      else passes++;
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 8; it++) begin
      int run_len = int'($urandom_range(1, 160));
      int rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_a) $display("FAIL random_a it=%0d t=%0d got=%h exp=%h", it, t_m, obs_a, exp_a);
        else passes++;
        checks++;
        if (obs_b !== exp_b) $display("FAIL random_b it=%0d t=%0d got=%h exp=%h", it, t_m, obs_b, exp_b);
        else passes++;
      end
      rst = 1'b1;
      for (int i = 0; i < rst_len; i++) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_a) $display("FAIL random_rst_a it=%0d got=%h exp=%h", it, obs_a, exp_a);
        else passes++;
      end
      rst = 1'b0;
    end
    for (int i = 0; i < 3 * A_FT; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) $display("FAIL random_tail_a t=%0d got=%h exp=%h", t_m, obs_a, exp_a);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_polarity_frame();
    test_mid_frame_reset();
    test_random_resets();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
